// File: rtl/ddr_wr_packer.sv
// ddr_wr_packer: packs an RGB565 pixel stream into wide DDR words, buffers
// them in a 64-entry FIFO and issues fixed-length write bursts whose address
// walks linearly through one frame buffer and wraps at the end of the frame.
module ddr_wr_packer #(
   parameter int          DQ_WIDTH  = 32,
   parameter int          H_WIDTH   = 1280,
   parameter int          H_HEIGHT  = 720,
   parameter int          BURST_LEN = 16,
   parameter logic [27:0] BASE_ADDR = 28'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vs_in,
   input  logic                  pix_de,
   input  logic [15:0]           pix_data,
   output logic                  wr_req,
   input  logic                  wr_ack,
   output logic [27:0]           wr_addr,
   output logic [DQ_WIDTH*8-1:0] wr_data,
   output logic                  wr_data_valid,
   input  logic                  wr_data_ready,
   output logic                  wr_last,
   output logic                  frame_done,
   output logic                  overflow,
   output logic [6:0]            fill_level
);

   localparam int          WORD_W    = DQ_WIDTH * 8;
   localparam int          BURSTS    = (H_WIDTH * H_HEIGHT) / (16 * BURST_LEN);
   localparam int          BC_W      = $clog2(BURSTS + 1);
   localparam int          BEAT_W    = $clog2(BURST_LEN + 1);
   localparam logic [27:0] ADDR_STEP = 28'(BURST_LEN * DQ_WIDTH);
   localparam logic [6:0]  FIFO_FULL = 7'd64;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   // registers
   logic              r_vs_prev;
   logic [3:0]        r_pix_idx;
   logic [WORD_W-1:0] r_pack;
   logic              r_resync;
   logic              r_overflow;
   logic [WORD_W-1:0] r_mem [0:63];
   logic [5:0]        r_wr_ptr;
   logic [5:0]        r_rd_ptr;
   logic [6:0]        r_count;
   logic [WORD_W-1:0] r_wr_data;
   logic [1:0]        r_state;
   logic [BEAT_W-1:0] r_beat;
   logic [BC_W-1:0]   r_burst_cnt;
   logic [27:0]       r_addr;
   logic              r_frame_done;

   // wires
   logic              w_vs_rise;
   logic              w_pix_accept;
   logic              w_word_done;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_last_beat;
   logic [5:0]        w_rd_ptr_next;
   logic [WORD_W-1:0] w_word;

   // Pixels arriving on a frame-sync edge or while a resync is pending are
   // discarded so that the next frame always starts word-aligned.
   assign w_vs_rise    = vs_in & ~r_vs_prev;
   assign w_pix_accept = pix_de & ~r_resync & ~w_vs_rise;
   assign w_word_done  = w_pix_accept & (r_pix_idx == 4'd15);
   assign w_full       = (r_count == FIFO_FULL);
   assign w_push       = w_word_done & ~w_full;
   assign w_pop        = (r_state == S_DATA) & wr_data_ready;
   assign w_flush      = (r_state == S_IDLE) & r_resync;
   assign w_last_beat  = (r_state == S_DATA) && (r_beat == BEAT_W'(BURST_LEN - 1));

   // Head pointer for the registered RAM read: follows a pop or a flush so the
   // output register always shows the word at the FIFO head one cycle later.
   assign w_rd_ptr_next = w_flush ? r_wr_ptr : (w_pop ? r_rd_ptr + 6'd1 : r_rd_ptr);

   // The completing pixel bypasses the pack register straight into the word.
   always_comb begin
      w_word                  = r_pack;
      w_word[WORD_W-1 -: 16]  = pix_data;
   end

   // Frame-sync edge detection and pixel index within the current word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vs_prev <= 1'b0;
         r_pix_idx <= 4'd0;
      end else begin
         r_vs_prev <= vs_in;
         if (w_vs_rise)
            r_pix_idx <= 4'd0;
         else if (w_pix_accept)
            r_pix_idx <= r_pix_idx + 4'd1;
      end
   end

   // Lane store for pixels 0..14 of the word being assembled.
   always_ff @(posedge clk) begin
      if (w_pix_accept)
         r_pack[{r_pix_idx, 4'b0000} +: 16] <= pix_data;
   end

   // FIFO storage (no reset so it maps onto block RAM).
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_word;
   end

   // FIFO pointers and occupancy; a flush empties the FIFO in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 6'd0;
         r_rd_ptr <= 6'd0;
         r_count  <= 7'd0;
      end else if (w_flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= 7'd0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 6'd1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 6'd1;
         if (w_push && !w_pop)
            r_count <= r_count + 7'd1;
         else if (!w_push && w_pop)
            r_count <= r_count - 7'd1;
      end
   end

   // Registered RAM read giving first-word-fall-through output data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wr_data <= '0;
      else
         r_wr_data <= r_mem[w_rd_ptr_next];
   end

   // Sticky drop flag, cleared only by the resync flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_overflow <= 1'b0;
      else if (w_flush)
         r_overflow <= 1'b0;
      else if (w_word_done && w_full)
         r_overflow <= 1'b1;
   end

   // Resync pending: a new edge takes priority over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_resync <= 1'b0;
      else if (w_vs_rise)
         r_resync <= 1'b1;
      else if (w_flush)
         r_resync <= 1'b0;
   end

   // Burst control: request, data beats, address and per-frame burst count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_beat       <= '0;
         r_burst_cnt  <= '0;
         r_addr       <= BASE_ADDR;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_resync) begin
                  r_addr      <= BASE_ADDR;
                  r_burst_cnt <= '0;
               end else if (r_count >= 7'(BURST_LEN) && !w_vs_rise) begin
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (wr_ack) begin
                  r_state <= S_DATA;
                  r_beat  <= '0;
               end
            end
            S_DATA: begin
               if (w_pop) begin
                  if (w_last_beat) begin
                     r_state <= S_IDLE;
                     if (r_burst_cnt == BC_W'(BURSTS - 1)) begin
                        r_burst_cnt  <= '0;
                        r_addr       <= BASE_ADDR;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_burst_cnt <= r_burst_cnt + BC_W'(1);
                        r_addr      <= r_addr + ADDR_STEP;
                     end
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_req        = (r_state == S_REQ);
   assign wr_data_valid = (r_state == S_DATA);
   assign wr_last       = w_last_beat;
   assign wr_addr       = r_addr;
   assign wr_data       = r_wr_data;
   assign frame_done    = r_frame_done;
   assign overflow      = r_overflow;
   assign fill_level    = r_count;

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Testbench for ddr_wr_packer: directed phases with random data, checked every
// cycle against a queue-based model of the packer, FIFO and burst sequence.
module tb_ddr_wr_packer;

   localparam int          BL   = 16;
   localparam int          HW   = 256;
   localparam int          HH   = 4;
   localparam int          NB   = HW * HH / (16 * BL);
   localparam logic [27:0] BASE = 28'h0;
   localparam logic [27:0] STEP = 28'd512;

   logic         clk = 1'b0;
   logic         rst;
   logic         vs_in;
   logic         pix_de;
   logic [15:0]  pix_data;
   logic         wr_req;
   logic         wr_ack;
   logic [27:0]  wr_addr;
   logic [255:0] wr_data;
   logic         wr_data_valid;
   logic         wr_data_ready;
   logic         wr_last;
   logic         frame_done;
   logic         overflow;
   logic [6:0]   fill_level;

   ddr_wr_packer #(
      .DQ_WIDTH(32), .H_WIDTH(HW), .H_HEIGHT(HH), .BURST_LEN(BL), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .vs_in(vs_in), .pix_de(pix_de), .pix_data(pix_data),
      .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
      .wr_last(wr_last), .frame_done(frame_done), .overflow(overflow),
      .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [255:0] q[$];
   logic [15:0]  part[$];
   int           m_ph;        // 0 idle, 1 requesting, 2 transferring
   int           m_beat, m_bcnt, req_wait;
   logic [27:0]  m_addr;
   bit           m_ovf, m_fd, m_pend, m_vsp;

   // stimulus knobs and bookkeeping
   int           ack_delay, ready_mode;
   int           n_checks, n_fail;
   int           n_frames, n_last;
   logic [27:0]  burst_log[$];
   bit           got_first;
   logic [255:0] first_word;
   logic [15:0]  seqv;

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete(); part.delete();
      m_ph = 0; m_beat = 0; m_bcnt = 0; req_wait = 0;
      m_addr = BASE; m_ovf = 0; m_fd = 0; m_pend = 0; m_vsp = 0;
   endtask

   task automatic reset_checks(string tag);
      chk({tag, "_req"}, wr_req, 0);
      chk({tag, "_valid"}, wr_data_valid, 0);
      chk({tag, "_last"}, wr_last, 0);
      chk({tag, "_fdone"}, frame_done, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_data"}, wr_data, 0);
      chk({tag, "_addr"}, wr_addr, BASE);
      chk({tag, "_fill"}, fill_level, 0);
   endtask

   // One clock: drive handshakes, compare outputs, advance the model.
   task automatic cycle();
      int          old_sz;
      bit          full, rise, acc, nfd;
      logic [255:0] w;
      wr_ack = (m_ph == 1 && req_wait >= ack_delay);
      case (ready_mode)
         0:       wr_data_ready = 1'b1;
         1:       wr_data_ready = ~wr_data_ready;
         default: wr_data_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("wr_req", wr_req, (m_ph == 1));
      chk("wr_data_valid", wr_data_valid, (m_ph == 2));
      chk("wr_addr", wr_addr, m_addr);
      chk("fill_level", fill_level, q.size());
      chk("overflow", overflow, m_ovf);
      chk("frame_done", frame_done, m_fd);
      if (m_ph == 2 && q.size() > 0) begin
         chk("wr_data", wr_data, q[0]);
         chk("wr_last", wr_last, (m_beat == BL - 1));
      end
      if (frame_done) n_frames++;
      if (m_ph == 1 && wr_ack) burst_log.push_back(wr_addr);
      if (m_ph == 2 && wr_data_ready && !got_first) begin
         got_first = 1; first_word = wr_data;
      end
      if (wr_data_valid && wr_data_ready && wr_last) n_last++;

      old_sz = q.size();
      full   = (old_sz == 64);
      rise   = vs_in && !m_vsp;
      acc    = pix_de && !m_pend && !rise;
      nfd    = 0;
      case (m_ph)
         0: begin
            if (m_pend) begin
               q.delete(); m_addr = BASE; m_bcnt = 0; m_ovf = 0; m_pend = 0;
            end else if (old_sz >= BL && !rise) begin
               m_ph = 1; req_wait = 0;
            end
         end
         1: begin
            if (wr_ack) begin m_ph = 2; m_beat = 0; end
            else req_wait++;
         end
         default: begin
            if (wr_data_ready) begin
               void'(q.pop_front());
               if (m_beat == BL - 1) begin
                  m_ph = 0;
                  if (m_bcnt == NB - 1) begin
                     m_bcnt = 0; m_addr = BASE; nfd = 1;
                  end else begin
                     m_bcnt++; m_addr = m_addr + STEP;
                  end
               end else m_beat++;
            end
         end
      endcase
      if (rise) part.delete();
      else if (acc) begin
         part.push_back(pix_data);
         if (part.size() == 16) begin
            for (int k = 0; k < 16; k++) w[16*k +: 16] = part[k];
            if (full) m_ovf = 1;
            else q.push_back(w);
            part.delete();
         end
      end
      if (rise) m_pend = 1;
      m_vsp = vs_in;
      m_fd  = nfd;
      @(posedge clk); #1;
   endtask

   task automatic feed(int n, int pct, bit seq);
      int sent = 0;
      while (sent < n) begin
         pix_de   = ($urandom_range(0, 99) < pct);
         pix_data = seq ? seqv : 16'($urandom);
         cycle();
         if (pix_de) begin sent++; seqv++; end
      end
      pix_de = 1'b0;
   endtask

   task automatic drain(int maxc);
      int c = 0;
      pix_de = 1'b0;
      while ((m_ph != 0 || q.size() >= BL || m_pend) && c < maxc) begin
         cycle(); c++;
      end
      chk("drain_timeout", (c < maxc), 1);
      repeat (2) cycle();
   endtask

   task automatic run_until_data(int maxc);
      int c = 0;
      while (m_ph != 2 && c < maxc) begin
         pix_de = 1'b1; pix_data = 16'($urandom);
         cycle(); c++;
      end
      chk("wait_data_timeout", (c < maxc), 1);
   endtask

   initial begin
      int           idx;
      logic [255:0] exp_w;
      n_checks = 0; n_fail = 0; n_frames = 0; n_last = 0; got_first = 0;
      seqv = 16'd0; ack_delay = 1; ready_mode = 0;
      rst = 1'b1; vs_in = 1'b0; pix_de = 1'b0; pix_data = 16'd0;
      wr_ack = 1'b0; wr_data_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_checks("reset");
      rst = 1'b0;
      repeat (2) cycle();

      // packing: sequential pixels 0..255 form exactly one burst
      feed(256, 100, 1);
      drain(200);
      for (int k = 0; k < 16; k++) exp_w[16*k +: 16] = 16'(k);
      chk("pack_first_word", first_word, exp_w);
      chk("pack_burst_count", burst_log.size(), 1);
      if (burst_log.size() > 0) chk("pack_burst_addr", burst_log[0], 28'h0);
      chk("pack_last_count", n_last, 1);

      // handshake: late ack, toggling ready
      ack_delay = 10; ready_mode = 1;
      feed(256, 100, 0);
      drain(300);
      chk("hs_burst_count", burst_log.size(), 2);
      if (burst_log.size() > 1) chk("hs_burst_addr", burst_log[1], STEP);
      chk("hs_last_count", n_last, 2);

      // overflow: no ack, continuous pixels
      ack_delay = 100000; ready_mode = 0;
      feed(64 * 16 + 40, 100, 0);
      chk("ovf_fill_sat", fill_level, 64);
      chk("ovf_flag", overflow, 1);
      vs_in = 1'b1; cycle();
      ack_delay = 2;
      drain(200);
      vs_in = 1'b0; cycle();
      chk("ovf_cleared", overflow, 0);
      chk("ovf_fill_flushed", fill_level, 0);

      // frame wrap: one full frame plus one more burst
      burst_log.delete(); n_frames = 0; ack_delay = 1; ready_mode = 0;
      feed(HW * HH + 256, 100, 1);
      drain(300);
      chk("frame_done_count", n_frames, 1);
      chk("frame_burst_count", burst_log.size(), NB + 1);
      if (burst_log.size() == NB + 1) begin
         chk("frame_last_addr", burst_log[NB-1], STEP * (NB - 1));
         chk("frame_wrap_addr", burst_log[NB], BASE);
      end

      // resync: partial word of 7 pixels, then an edge during DATA
      feed(7, 100, 0);
      vs_in = 1'b1; cycle(); vs_in = 1'b0;
      burst_log.delete();
      feed(512, 100, 0);
      drain(300);
      chk("resync_first_addr", (burst_log.size() > 0) ? burst_log[0] : 28'hFFFFFFF, 28'h0);
      run_until_data(300);
      idx = burst_log.size();
      vs_in = 1'b1; cycle(); vs_in = 1'b0;
      feed(300, 100, 0);
      drain(300);
      chk("resync_next_exists", (burst_log.size() > idx), 1);
      if (burst_log.size() > idx) chk("resync_next_addr", burst_log[idx], 28'h0);

      // random traffic
      for (int r = 0; r < 4; r++) begin
         ack_delay = $urandom_range(0, 5); ready_mode = 2;
         feed(500, 70, 0);
      end
      ready_mode = 0; ack_delay = 1;
      drain(400);

      // reset while transferring
      ready_mode = 1;
      feed(256, 100, 0);
      run_until_data(300);
      cycle();
      #2 rst = 1'b1;
      #1;
      reset_checks("midburst_rst");
      model_reset();
      pix_de = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      burst_log.delete();
      ready_mode = 0;
      feed(256, 100, 0);
      drain(300);
      chk("post_rst_addr", (burst_log.size() > 0) ? burst_log[0] : 28'hFFFFFFF, BASE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_wr_packer.md
DDR_WR_PACKER -- requirements
Module: ddr_wr_packer

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 32; the DDR word is DQ_WIDTH*8 = 256 bits, which holds 16 RGB565 pixels.
REQ-002 SHALL have parameter H_WIDTH, default 1280; the frame width in pixels.
REQ-003 SHALL have parameter H_HEIGHT, default 720; the frame height in lines.
REQ-004 SHALL have parameter BURST_LEN, default 16; the number of words per write burst.
REQ-005 SHALL have parameter BASE_ADDR, default 28'h0; the byte address of the frame start.
REQ-006 SHALL have the following ports, clock and reset first (name, direction, width, meaning).
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- vs_in  in  1  frame sync; a rising edge marks a new frame.
- pix_de  in  1  pix_data is valid this cycle.
- pix_data  in  16  RGB565 pixel.
- wr_req  out  1  burst request.
- wr_ack  in  1  one-cycle request acceptance.
- wr_addr  out  28  burst byte address.
- wr_data  out  DQ_WIDTH*8  burst data word.
- wr_data_valid  out  1  wr_data is valid.
- wr_data_ready  in  1  the consumer accepts wr_data.
- wr_last  out  1  marks the final word of the burst.
- frame_done  out  1  one-cycle pulse after the last burst of a frame.
- overflow  out  1  sticky flag: a word was dropped.
- fill_level  out  7  number of words held in the buffer (0..64).

Function
REQ-007 SHALL pack 16 pixels per word: the first pixel goes in bits [15:0], and pixel k goes in bits [16k+15:16k].
REQ-008 SHALL count accepted pixels with a 4-bit index; a word completes when the 16th pixel is accepted, and the index then wraps to 0.
REQ-009 SHALL write each completed word into a 64-entry FIFO, and fill_level SHALL reflect the write in the next cycle.
REQ-010 SHALL drop a completed word when the FIFO is full, with no corruption of the FIFO, and SHALL then set overflow to 1.
REQ-011 SHALL keep overflow set until the next vs_in rising edge.
REQ-012 SHALL let the FIFO be written and read in the same cycle, with fill_level unchanged in that case.
REQ-013 SHALL implement a control FSM with states IDLE, REQ and DATA.
REQ-014 SHALL move from IDLE to REQ when fill_level >= BURST_LEN and no resync is pending; wr_req SHALL assert in the cycle after the condition is met.
REQ-015 SHALL hold wr_req and wr_addr stable in REQ until wr_ack=1, then move to DATA in the next cycle with wr_req=0.
REQ-016 SHALL in DATA present FIFO head words with wr_data_valid=1 (first-word-fall-through).
REQ-017 SHALL pop a word only when wr_data_valid && wr_data_ready, and SHALL hold wr_data stable while wr_data_ready=0.
REQ-018 SHALL assert wr_last with the BURST_LEN-th word of the burst.
REQ-019 SHALL return to IDLE on the accepted wr_last word.
REQ-020 SHALL, on each completed burst, advance wr_addr by BURST_LEN*DQ_WIDTH bytes (512 by default).
REQ-021 SHALL count bursts per frame: H_WIDTH*H_HEIGHT/(16*BURST_LEN), which is 3600 by default.
REQ-022 SHALL, after the final burst of a frame, reload wr_addr to BASE_ADDR and pulse frame_done for one cycle, coincident with the return to IDLE.
REQ-023 SHALL detect a vs_in rising edge with a registered previous value.
REQ-024 SHALL, on a vs_in rising edge, immediately clear the pixel index, discard any partial word, and set a resync-pending flag.
REQ-025 SHALL, while resync is pending, ignore pix_de and block IDLE->REQ.
REQ-026 SHALL leave an in-flight burst (REQ or DATA) to complete normally when a vs_in edge occurs.
REQ-027 SHALL, in the first IDLE cycle with resync pending, flush the FIFO (fill_level to 0), reload wr_addr to BASE_ADDR, clear the burst count, clear overflow and clear the pending flag.
REQ-028 SHALL, if a vs_in edge and a word completion coincide, discard the word.

Reset
REQ-029 SHALL, while rst=1, force the following values asynchronously, and SHALL release synchronously to clk.
- FSM state: IDLE.
- wr_req, wr_data_valid, wr_last, frame_done and overflow: 0.
- wr_data: 0.
- wr_addr: BASE_ADDR.
- fill_level: 0.
- Pixel index, burst count and resync flag: 0.
- Previous-vs register: 0.
REQ-030 SHALL, when rst asserts mid-burst, abandon the burst without issuing wr_last.

Verification
REQ-031 SHALL verify packing: stream 256 pixels with pix_data=0..255 -> one burst at wr_addr 0x0; word 0 is {16'd15,...,16'd0} and wr_last is set on the 16th word.
REQ-032 SHALL verify the handshake: hold wr_ack=0 for 10 cycles -> wr_req and wr_addr stay stable; then toggle wr_data_ready 1/0 -> exactly 16 words are popped, in order, with wr_data held during stalls.
REQ-033 SHALL verify overflow: pix_de=1 continuously with wr_ack=0 -> fill_level saturates at 64 and overflow=1; the next vs_in edge clears overflow and fill_level to 0.
REQ-034 SHALL verify frame wrap: send a full 1280x720 frame with ready=1 -> 3600 bursts with the last at address 0x1C1E00, a frame_done pulse, and a next burst at 0x0.
REQ-035 SHALL verify resync: a vs_in edge after 7 pixels, and during DATA -> the burst completes, the partial word is discarded, the FIFO is flushed and the next burst goes to 0x0.
REQ-036 SHALL verify reset: assert rst during DATA -> all outputs take their REQ-029 values within the same cycle.
